datapath: RTL and testbench
===========================

DATAPATH -- requirements
Module: datapath

Interface
- REQ-001 SHALL list ports in exactly the order below, because instantiation is positional.
- REQ-002 SHALL define `clock` as input, 1 bit: the single system clock; all state updates on the rising edge.
- REQ-003 SHALL define `clear` as input, 1 bit: reset, synchronous and active-high.
- REQ-004 SHALL define `R0in`..`R15in` as 16 inputs, 1 bit each: load general register Rn from the bus.
- REQ-005 SHALL define `R0out`..`R15out` as 16 inputs, 1 bit each: drive Rn onto the bus.
- REQ-006 SHALL define `HIin`, `LOin`, `HIout`, `LOout` as inputs, 1 bit each: load or drive the HI and LO registers.
- REQ-007 SHALL define `Zhighin`, `Zlowin`, `Zhighout`, `Zlowout` as inputs, 1 bit each: load Z[63:32] or Z[31:0] from the ALU result, or drive that half onto the bus.
- REQ-008 SHALL define `PCin`, `PCout`, `MDRin`, `MDRout`, `MARin`, `MARout` as inputs, 1 bit each: load or drive PC, MDR and MAR.
- REQ-009 SHALL define `InPortin`, `InPortout`, `CSEin`, `CSEout`, `IRin`, `IRout` as inputs, 1 bit each: load or drive the input port, the sign-extended C field and IR.
- REQ-010 SHALL define `Mdatain` as input, 32 bits: memory read data.
- REQ-011 SHALL define `MDMuxread` as input, 1 bit: MDR source select (1 = `Mdatain`, 0 = bus).
- REQ-012 SHALL define `Yin` as input, 1 bit: load Y from the bus.
- REQ-013 SHALL define `ADD`, `SUB`, `MUL`, `DIV`, `AND`, `OR`, `SHR`, `SHRA`, `SHL`, `ROR`, `ROL`, `NEG`, `NOT`, `IncPC` as inputs, 1 bit each: ALU operation selects.
- REQ-014 SHALL have no other ports unless `DATAPATH_DEBUG_EN` is defined (see REQ-033).

Function
- REQ-015 SHALL have a single 32-bit bus driven by a multiplexer, with no tri-states.
- REQ-016 SHALL resolve bus sources by fixed priority: R0out..R15out, HIout, LOout, Zhighout, Zlowout, PCout, MDRout, MARout, InPortout, CSEout, IRout; with no source asserted, the bus SHALL be 0.
- REQ-017 SHALL load every 32-bit register (R0–R15, HI, LO, PC, MDR, MAR, InPort, CSE, IR, Y) on the rising clock edge while its *in* signal is high, otherwise hold.
- REQ-018 SHALL treat R0 as an ordinary register.
- REQ-019 SHALL load MDR from `Mdatain` when `MDMuxread`=1, else from the bus.
- REQ-020 SHALL load InPort and CSE from the bus.
- REQ-021 SHALL drive `CSEout` as sign-extended IR[18:0].
- REQ-022 SHALL form the ALU operands as A = Y and B = bus, producing a 64-bit combinational result; Z[63:32] and Z[31:0] load independently on `Zhighin` and `Zlowin`.
- REQ-023 SHALL compute these ALU operations, with any unused upper half 0:
  - ADD: A+B.
  - SUB: A−B.
  - AND, OR: bitwise.
  - NOT: ~B.
  - NEG: −B.
  - IncPC: B+1.
  - SHR, SHRA, SHL, ROR, ROL: shift or rotate A by B[4:0].
  - All of the above wrap modulo 2^32.
- REQ-024 SHALL compute MUL as the signed 64-bit product A×B.
- REQ-025 SHALL compute DIV as signed quotient in the low half and remainder in the high half; when B=0, quotient SHALL be 0xFFFFFFFF and remainder A.
- REQ-026 SHALL give ALU selects priority in the order IncPC, ADD, SUB, MUL, DIV, AND, OR, SHR, SHRA, SHL, ROR, ROL, NEG, NOT; with none asserted, the result SHALL be 0.
- REQ-027 SHALL have a transfer latency of one edge (source out + destination in in the same cycle); simultaneous drive and load of the same register SHALL load the pre-edge value.

Reset
- REQ-028 SHALL, while `clear`=1 at a rising edge, set every register (R0–R15, HI, LO, Z, PC, MDR, MAR, InPort, CSE, IR, Y) to 0.
- REQ-029 SHALL give `clear` priority over all *in* signals.
- REQ-030 SHALL treat `clear` asserted mid-sequence as aborting it, with no partial loads.
- REQ-031 SHALL, without a clock edge, leave registers unchanged even if `clear` pulses.

Configuration
- REQ-032 SHALL provide the macro `DATAPATH_DEBUG_EN`.
- REQ-033 SHALL, with `DATAPATH_DEBUG_EN` defined, append output ports after `IncPC`:
  - `BusMuxOut`, 32 bits.
  - `R1_dbg`, 32 bits.
  - `Z_dbg`, 64 bits.
  - `PC_dbg`, 32 bits.
- REQ-034 SHALL, without `DATAPATH_DEBUG_EN`, omit those ports, with identical internal behaviour.

Structure
- REQ-035 SHALL place in a shared package: the word width (32), the register count (16), the ALU opcode enumeration and the bus-source priority constants.
- REQ-036 SHALL implement one sub-module, `reg32`: a 32-bit register with synchronous clear and load enable, instantiated per register (Z as two instances).
- REQ-037 SHALL keep the ALU inline.

Verification
- REQ-038 SHALL verify ADD: R2=0xFFFFEC78 and R3=0x00004E20 loaded via MDR; R2out/Yin, then R3out/ADD/Zlowin, then Zlowout/R1in → R1=0x00003A98.
- REQ-039 SHALL verify fetch: PC=0, then PCout/MARin/IncPC/Zlowin, then Zlowout/PCin with MDMuxread/MDRin and `Mdatain`=0x18918000, then MDRout/IRin → MAR=0, PC=1, IR=0x18918000.
- REQ-040 SHALL verify MUL: Y=0xFFFFFFFE, B=3, Zhighin+Zlowin → Z=0xFFFFFFFF_FFFFFFFA; HI/LO loaded via Zhighout/Zlowout.
- REQ-041 SHALL verify DIV: Y=17, B=5 → Zlow=3, Zhigh=2; Y=17, B=0 → Zlow=0xFFFFFFFF, Zhigh=17.
- REQ-042 SHALL verify shifts: Y=0x80000001, B=1:
  - SHR → 0x40000000.
  - SHRA → 0xC0000000.
  - ROL → 0x00000003.
  - ROR → 0xC0000000.
- REQ-043 SHALL verify reset: with all registers nonzero, `clear`=1 for one edge → every register reads 0 through its out path; concurrent R1in is ignored.

Source files
------------

// File: rtl/datapath_pkg.sv
// rtl/datapath_pkg.sv - shared widths, ALU opcodes and bus-source priority indices for the datapath
package datapath_pkg;

    localparam int WORD_W   = 32;
    localparam int NUM_REGS = 16;

    // Internal ALU operation, decoded from the one-hot select inputs by priority.
    typedef enum logic [3:0] {
        ALU_NONE,
        ALU_INCPC,
        ALU_ADD,
        ALU_SUB,
        ALU_MUL,
        ALU_DIV,
        ALU_AND,
        ALU_OR,
        ALU_SHR,
        ALU_SHRA,
        ALU_SHL,
        ALU_ROR,
        ALU_ROL,
        ALU_NEG,
        ALU_NOT
    } alu_op_t;

    // Bus sources, lowest index wins. General registers occupy 0..NUM_REGS-1.
    localparam int SRC_R0     = 0;
    localparam int SRC_HI     = 16;
    localparam int SRC_LO     = 17;
    localparam int SRC_ZHIGH  = 18;
    localparam int SRC_ZLOW   = 19;
    localparam int SRC_PC     = 20;
    localparam int SRC_MDR    = 21;
    localparam int SRC_MAR    = 22;
    localparam int SRC_INPORT = 23;
    localparam int SRC_CSE    = 24;
    localparam int SRC_IR     = 25;
    localparam int SRC_COUNT  = 26;

    // The C field of an instruction is IR[18:0], sign-extended to a word.
    function automatic logic [WORD_W-1:0] cse_extend(input logic [WORD_W-1:0] ir);
        return {{(WORD_W-19){ir[18]}}, ir[18:0]};
    endfunction

endpackage

// File: rtl/datapath_reg32.sv
// rtl/datapath_reg32.sv - reg32: 32-bit register with synchronous clear and load enable
// Ports: clock, clear (sync, active-high, wins over load), load, d[31:0], q[31:0]
module reg32
    import datapath_pkg::*;
(
    input  logic              clock,
    input  logic              clear,
    input  logic              load,
    input  logic [WORD_W-1:0] d,
    output logic [WORD_W-1:0] q
);

    always_ff @(posedge clock) begin
        if (clear) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/datapath.sv
// rtl/datapath.sv - 32-bit single-bus CPU datapath: register file, special registers, muxed bus, inline ALU
// Ports: clock, clear (sync active-high); Rn/HI/LO/Z/PC/MDR/MAR/InPort/CSE/IR in/out strobes;
//        Mdatain[31:0] memory data, MDMuxread MDR source select, Yin, ALU op selects ADD..IncPC.
// Macro DATAPATH_DEBUG_EN appends outputs BusMuxOut[31:0], R1_dbg[31:0], Z_dbg[63:0], PC_dbg[31:0].
module datapath
    import datapath_pkg::*;
(
    input  logic clock,
    input  logic clear,
    input  logic R0in,  input  logic R1in,  input  logic R2in,  input  logic R3in,
    input  logic R4in,  input  logic R5in,  input  logic R6in,  input  logic R7in,
    input  logic R8in,  input  logic R9in,  input  logic R10in, input  logic R11in,
    input  logic R12in, input  logic R13in, input  logic R14in, input  logic R15in,
    input  logic R0out,  input  logic R1out,  input  logic R2out,  input  logic R3out,
    input  logic R4out,  input  logic R5out,  input  logic R6out,  input  logic R7out,
    input  logic R8out,  input  logic R9out,  input  logic R10out, input  logic R11out,
    input  logic R12out, input  logic R13out, input  logic R14out, input  logic R15out,
    input  logic HIin,
    input  logic LOin,
    input  logic HIout,
    input  logic LOout,
    input  logic Zhighin,
    input  logic Zlowin,
    input  logic Zhighout,
    input  logic Zlowout,
    input  logic PCin,
    input  logic PCout,
    input  logic MDRin,
    input  logic MDRout,
    input  logic MARin,
    input  logic MARout,
    input  logic InPortin,
    input  logic InPortout,
    input  logic CSEin,
    input  logic CSEout,
    input  logic IRin,
    input  logic IRout,
    input  logic [WORD_W-1:0] Mdatain,
    input  logic MDMuxread,
    input  logic Yin,
    input  logic ADD,
    input  logic SUB,
    input  logic MUL,
    input  logic DIV,
    input  logic AND,
    input  logic OR,
    input  logic SHR,
    input  logic SHRA,
    input  logic SHL,
    input  logic ROR,
    input  logic ROL,
    input  logic NEG,
    input  logic NOT,
    input  logic IncPC
`ifdef DATAPATH_DEBUG_EN
    ,
    output logic [WORD_W-1:0]   BusMuxOut,
    output logic [WORD_W-1:0]   R1_dbg,
    output logic [2*WORD_W-1:0] Z_dbg,
    output logic [WORD_W-1:0]   PC_dbg
`endif
);

    logic [WORD_W-1:0]    bus;
    logic [WORD_W-1:0]    src [SRC_COUNT];
    logic [SRC_COUNT-1:0] src_sel;
    logic [NUM_REGS-1:0]  r_load;
    logic [WORD_W-1:0]    r_q [NUM_REGS];
    logic [WORD_W-1:0]    hi_q, lo_q, zhigh_q, zlow_q, pc_q, mdr_q, mar_q, inport_q, ir_q, y_q;
    // The CSE register is loadable but never drives the bus: CSEout sign-extends IR directly.
    logic [WORD_W-1:0]    cse_unused;
    logic [WORD_W-1:0]    mdr_d;
    logic [2*WORD_W-1:0]  alu_result;

    assign r_load = {R15in, R14in, R13in, R12in, R11in, R10in, R9in, R8in,
                     R7in,  R6in,  R5in,  R4in,  R3in,  R2in,  R1in, R0in};

    assign src_sel = {IRout, CSEout, InPortout, MARout, MDRout, PCout, Zlowout, Zhighout, LOout, HIout,
                      R15out, R14out, R13out, R12out, R11out, R10out, R9out, R8out,
                      R7out,  R6out,  R5out,  R4out,  R3out,  R2out,  R1out, R0out};

    // ---------------- registers ----------------
    for (genvar i = 0; i < NUM_REGS; i++) begin : g_gpr
        reg32 u_r (.clock(clock), .clear(clear), .load(r_load[i]), .d(bus), .q(r_q[i]));
        assign src[SRC_R0 + i] = r_q[i];
    end

    assign mdr_d = MDMuxread ? Mdatain : bus;

    reg32 u_hi     (.clock(clock), .clear(clear), .load(HIin),     .d(bus),                      .q(hi_q));
    reg32 u_lo     (.clock(clock), .clear(clear), .load(LOin),     .d(bus),                      .q(lo_q));
    reg32 u_zhigh  (.clock(clock), .clear(clear), .load(Zhighin),  .d(alu_result[63:32]),        .q(zhigh_q));
    reg32 u_zlow   (.clock(clock), .clear(clear), .load(Zlowin),   .d(alu_result[31:0]),         .q(zlow_q));
    reg32 u_pc     (.clock(clock), .clear(clear), .load(PCin),     .d(bus),                      .q(pc_q));
    reg32 u_mdr    (.clock(clock), .clear(clear), .load(MDRin),    .d(mdr_d),                    .q(mdr_q));
    reg32 u_mar    (.clock(clock), .clear(clear), .load(MARin),    .d(bus),                      .q(mar_q));
    reg32 u_inport (.clock(clock), .clear(clear), .load(InPortin), .d(bus),                      .q(inport_q));
    reg32 u_cse    (.clock(clock), .clear(clear), .load(CSEin),    .d(bus),                      .q(cse_unused));
    reg32 u_ir     (.clock(clock), .clear(clear), .load(IRin),     .d(bus),                      .q(ir_q));
    reg32 u_y      (.clock(clock), .clear(clear), .load(Yin),      .d(bus),                      .q(y_q));

    assign src[SRC_HI]     = hi_q;
    assign src[SRC_LO]     = lo_q;
    assign src[SRC_ZHIGH]  = zhigh_q;
    assign src[SRC_ZLOW]   = zlow_q;
    assign src[SRC_PC]     = pc_q;
    assign src[SRC_MDR]    = mdr_q;
    assign src[SRC_MAR]    = mar_q;
    assign src[SRC_INPORT] = inport_q;
    assign src[SRC_CSE]    = cse_extend(ir_q);
    assign src[SRC_IR]     = ir_q;

    // ---------------- bus mux ----------------
    // Walk from lowest priority upward so the highest-priority asserted source is assigned last.
    always_comb begin
        bus = '0;
        for (int i = SRC_COUNT - 1; i >= 0; i--) begin
            if (src_sel[i]) bus = src[i];
        end
    end

    // ---------------- ALU ----------------
    logic [WORD_W-1:0]   a, b;
    logic [4:0]          sh;
    logic [2*WORD_W-1:0] prod;
    logic [WORD_W-1:0]   a_mag, b_mag, q_mag, r_mag, quo, rem;
    alu_op_t             alu_op;

    assign a  = y_q;
    assign b  = bus;
    assign sh = b[4:0];

    // Sign-extending both operands to 64 bits makes the low 64 bits of the product the signed result.
    assign prod = {{WORD_W{a[31]}}, a} * {{WORD_W{b[31]}}, b};

    // Signed division done on magnitudes so the most-negative / -1 case never overflows.
    assign a_mag = a[31] ? -a : a;
    assign b_mag = b[31] ? -b : b;
    assign q_mag = a_mag / b_mag;
    assign r_mag = a_mag % b_mag;
    assign quo   = (a[31] ^ b[31]) ? -q_mag : q_mag;
    assign rem   = a[31] ? -r_mag : r_mag;

    always_comb begin
        if      (IncPC) alu_op = ALU_INCPC;
        else if (ADD)   alu_op = ALU_ADD;
        else if (SUB)   alu_op = ALU_SUB;
        else if (MUL)   alu_op = ALU_MUL;
        else if (DIV)   alu_op = ALU_DIV;
        else if (AND)   alu_op = ALU_AND;
        else if (OR)    alu_op = ALU_OR;
        else if (SHR)   alu_op = ALU_SHR;
        else if (SHRA)  alu_op = ALU_SHRA;
        else if (SHL)   alu_op = ALU_SHL;
        else if (ROR)   alu_op = ALU_ROR;
        else if (ROL)   alu_op = ALU_ROL;
        else if (NEG)   alu_op = ALU_NEG;
        else if (NOT)   alu_op = ALU_NOT;
        else            alu_op = ALU_NONE;
    end

    always_comb begin
        alu_result = '0;
        case (alu_op)
            ALU_INCPC: alu_result = {32'd0, b + 32'd1};
            ALU_ADD:   alu_result = {32'd0, a + b};
            ALU_SUB:   alu_result = {32'd0, a - b};
            ALU_MUL:   alu_result = prod;
            ALU_DIV:   alu_result = (b == '0) ? {a, 32'hFFFF_FFFF} : {rem, quo};
            ALU_AND:   alu_result = {32'd0, a & b};
            ALU_OR:    alu_result = {32'd0, a | b};
            ALU_SHR:   alu_result = {32'd0, a >> sh};
            ALU_SHRA:  alu_result = {32'd0, $signed(a) >>> sh};
            ALU_SHL:   alu_result = {32'd0, a << sh};
            ALU_ROR:   alu_result = {32'd0, (a >> sh) | (a << (6'd32 - {1'b0, sh}))};
            ALU_ROL:   alu_result = {32'd0, (a << sh) | (a >> (6'd32 - {1'b0, sh}))};
            ALU_NEG:   alu_result = {32'd0, -b};
            ALU_NOT:   alu_result = {32'd0, ~b};
            default:   alu_result = '0;
        endcase
    end

`ifdef DATAPATH_DEBUG_EN
    assign BusMuxOut = bus;
    assign R1_dbg    = r_q[1];
    assign Z_dbg     = {zhigh_q, zlow_q};
    assign PC_dbg    = pc_q;
`endif

endmodule

// File: tb/tb_datapath.sv
// tb/tb_datapath.sv - randomized and directed self-checking bench for datapath against a behavioural model
module tb_datapath;

    localparam int I_HI = 16, I_LO = 17, I_ZH = 18, I_ZL = 19, I_PC = 20;
    localparam int I_MDR = 21, I_MAR = 22, I_IN = 23, I_CSE = 24, I_IR = 25;
    localparam int O_INC = 0, O_ADD = 1, O_SUB = 2, O_MUL = 3, O_DIV = 4, O_AND = 5, O_OR = 6;
    localparam int O_SHR = 7, O_SHRA = 8, O_SHL = 9, O_ROR = 10, O_ROL = 11, O_NEG = 12, O_NOT = 13;

    logic        clock = 1'b0;
    logic        clear;
    logic [25:0] ins, outs;
    logic [13:0] op;
    logic [31:0] Mdatain;
    logic        MDMuxread, Yin;
    int          tests = 0, fails = 0;
    bit          check_en = 1'b0;

    always #5 clock = ~clock;

`ifdef DATAPATH_DEBUG_EN
    logic [31:0] dbg_bus, dbg_r1, dbg_pc;
    logic [63:0] dbg_z;
`endif

    datapath dut (
        .clock(clock), .clear(clear),
        .R0in(ins[0]),   .R1in(ins[1]),   .R2in(ins[2]),   .R3in(ins[3]),
        .R4in(ins[4]),   .R5in(ins[5]),   .R6in(ins[6]),   .R7in(ins[7]),
        .R8in(ins[8]),   .R9in(ins[9]),   .R10in(ins[10]), .R11in(ins[11]),
        .R12in(ins[12]), .R13in(ins[13]), .R14in(ins[14]), .R15in(ins[15]),
        .R0out(outs[0]),   .R1out(outs[1]),   .R2out(outs[2]),   .R3out(outs[3]),
        .R4out(outs[4]),   .R5out(outs[5]),   .R6out(outs[6]),   .R7out(outs[7]),
        .R8out(outs[8]),   .R9out(outs[9]),   .R10out(outs[10]), .R11out(outs[11]),
        .R12out(outs[12]), .R13out(outs[13]), .R14out(outs[14]), .R15out(outs[15]),
        .HIin(ins[16]), .LOin(ins[17]), .HIout(outs[16]), .LOout(outs[17]),
        .Zhighin(ins[18]), .Zlowin(ins[19]), .Zhighout(outs[18]), .Zlowout(outs[19]),
        .PCin(ins[20]), .PCout(outs[20]), .MDRin(ins[21]), .MDRout(outs[21]),
        .MARin(ins[22]), .MARout(outs[22]), .InPortin(ins[23]), .InPortout(outs[23]),
        .CSEin(ins[24]), .CSEout(outs[24]), .IRin(ins[25]), .IRout(outs[25]),
        .Mdatain(Mdatain), .MDMuxread(MDMuxread), .Yin(Yin),
        .ADD(op[1]), .SUB(op[2]), .MUL(op[3]), .DIV(op[4]), .AND(op[5]), .OR(op[6]),
        .SHR(op[7]), .SHRA(op[8]), .SHL(op[9]), .ROR(op[10]), .ROL(op[11]),
        .NEG(op[12]), .NOT(op[13]), .IncPC(op[0])
`ifdef DATAPATH_DEBUG_EN
        , .BusMuxOut(dbg_bus), .R1_dbg(dbg_r1), .Z_dbg(dbg_z), .PC_dbg(dbg_pc)
`endif
    );

    // ---------------- behavioural model ----------------
    logic [31:0] st [26];   // architectural registers indexed like the strobe vectors
    logic [31:0] y_m;
    logic [31:0] m_bus, m_cse;
    logic [63:0] m_alu;

    function automatic logic [63:0] ref_alu(input logic [13:0] sel, input logic [31:0] a, input logic [31:0] b);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        int     s  = int'(b[4:0]);
        logic [63:0] aa = {a, a};
        logic [63:0] t;
        int     first = -1;
        for (int i = 13; i >= 0; i--) if (sel[i]) first = i;
        case (first)
            O_INC:  return {32'd0, b + 32'd1};
            O_ADD:  return {32'd0, a + b};
            O_SUB:  return {32'd0, a - b};
            O_MUL:  return 64'(sa * sb);
            O_DIV: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                t = 64'(sa / sb);
                aa = 64'(sa % sb);
                return {aa[31:0], t[31:0]};
            end
            O_AND:  return {32'd0, a & b};
            O_OR:   return {32'd0, a | b};
            O_SHR:  return {32'd0, a >> s};
            O_SHRA: begin t = 64'(sa >>> s); return {32'd0, t[31:0]}; end
            O_SHL:  return {32'd0, a << s};
            O_ROR:  begin t = aa >> s; return {32'd0, t[31:0]}; end
            O_ROL:  begin t = aa << s; return {32'd0, t[63:32]}; end
            O_NEG:  return {32'd0, 32'd0 - b};
            O_NOT:  return {32'd0, ~b};
            default: return 64'd0;
        endcase
    endfunction

    assign m_cse = {{13{st[I_IR][18]}}, st[I_IR][18:0]};

    always_comb begin
        logic found;
        found = 1'b0;
        m_bus = '0;
        for (int i = 0; i < 26; i++) begin
            if (outs[i] && !found) begin
                found = 1'b1;
                m_bus = (i == I_CSE) ? m_cse : st[i];
            end
        end
    end

    assign m_alu = ref_alu(op, y_m, m_bus);

    always @(posedge clock) begin
        if (clear) begin
            for (int i = 0; i < 26; i++) st[i] <= '0;
            y_m <= '0;
        end else begin
            for (int i = 0; i < 26; i++) begin
                if (ins[i]) begin
                    if (i == I_ZH)                    st[i] <= m_alu[63:32];
                    else if (i == I_ZL)               st[i] <= m_alu[31:0];
                    else if (i == I_MDR && MDMuxread) st[i] <= Mdatain;
                    else                              st[i] <= m_bus;
                end
            end
            if (Yin) y_m <= m_bus;
        end
    end

    // Per-cycle comparison of the bus (and debug taps when present) against the model.
    always @(negedge clock) begin
        if (check_en) begin
            tests++;
            if (dut.bus !== m_bus) begin
                fails++;
                $display("FAIL bus_cycle t=%0t got %h want %h", $time, dut.bus, m_bus);
            end
`ifdef DATAPATH_DEBUG_EN
            tests++;
            if (dbg_bus !== m_bus || dbg_r1 !== st[1] || dbg_z !== {st[I_ZH], st[I_ZL]} || dbg_pc !== st[I_PC]) begin
                fails++;
                $display("FAIL debug_taps t=%0t got %h %h %h %h want %h %h %h %h", $time,
                         dbg_bus, dbg_r1, dbg_z, dbg_pc, m_bus, st[1], {st[I_ZH], st[I_ZL]}, st[I_PC]);
            end
`endif
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic idle_ctrl();
        ins = '0; outs = '0; op = '0; Yin = 1'b0; MDMuxread = 1'b0; clear = 1'b0;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        idle_ctrl();
    endtask

    task automatic read_src(input int idx, input logic [31:0] exp, input string name);
        outs = '0;
        outs[idx] = 1'b1;
        #1;
        tests++;
        if (dut.bus !== exp) begin
            fails++;
            $display("FAIL %s got %h want %h", name, dut.bus, exp);
        end
        outs[idx] = 1'b0;
    endtask

    task automatic load_mdr(input logic [31:0] v);
        Mdatain = v; MDMuxread = 1'b1; ins[I_MDR] = 1'b1;
        tick();
    endtask

    task automatic load_reg(input int idx, input logic [31:0] v);
        load_mdr(v);
        outs[I_MDR] = 1'b1; ins[idx] = 1'b1;
        tick();
    endtask

    task automatic load_y(input logic [31:0] v);
        load_mdr(v);
        outs[I_MDR] = 1'b1; Yin = 1'b1;
        tick();
    endtask

    // Y = a, bus = b from MDR, selected ops into both Z halves, then read both halves back.
    task automatic alu_check(input logic [31:0] a, input logic [31:0] b, input logic [13:0] sel,
                             input logic [31:0] exp_hi, input logic [31:0] exp_lo, input string name);
        load_y(a);
        load_mdr(b);
        outs[I_MDR] = 1'b1; op = sel; ins[I_ZH] = 1'b1; ins[I_ZL] = 1'b1;
        tick();
        read_src(I_ZL, exp_lo, {name, "_lo"});
        read_src(I_ZH, exp_hi, {name, "_hi"});
    endtask

    function automatic logic [13:0] one_op(input int i);
        logic [13:0] v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    initial begin
        idle_ctrl();
        Mdatain = '0;
        clear = 1'b1;
        tick();
        check_en = 1'b1;

        // Reset state of every bus source.
        for (int i = 0; i < 26; i++) read_src(i, 32'd0, $sformatf("reset_src%0d", i));

        // Instruction fetch from PC = 0.
        outs[I_PC] = 1'b1; ins[I_MAR] = 1'b1; op[O_INC] = 1'b1; ins[I_ZL] = 1'b1;
        tick();
        outs[I_ZL] = 1'b1; ins[I_PC] = 1'b1; MDMuxread = 1'b1; ins[I_MDR] = 1'b1; Mdatain = 32'h1891_8000;
        tick();
        outs[I_MDR] = 1'b1; ins[I_IR] = 1'b1;
        tick();
        read_src(I_MAR, 32'h0000_0000, "fetch_mar");
        read_src(I_PC,  32'h0000_0001, "fetch_pc");
        read_src(I_IR,  32'h1891_8000, "fetch_ir");
        read_src(I_CSE, 32'h0001_8000, "fetch_cse");

        // ADD through R2/R3 into R1.
        load_reg(2, 32'hFFFF_EC78);
        load_reg(3, 32'h0000_4E20);
        outs[2] = 1'b1; Yin = 1'b1; tick();
        outs[3] = 1'b1; op[O_ADD] = 1'b1; ins[I_ZL] = 1'b1; tick();
        outs[I_ZL] = 1'b1; ins[1] = 1'b1; tick();
        read_src(1, 32'h0000_3A98, "add_r1");

        // A clear pulse that never meets a rising edge changes nothing.
        clear = 1'b1; #1; clear = 1'b0;
        tick();
        read_src(1, 32'h0000_3A98, "clear_no_edge");

        // MUL then HI/LO.
        alu_check(32'hFFFF_FFFE, 32'd3, one_op(O_MUL), 32'hFFFF_FFFF, 32'hFFFF_FFFA, "mul");
        outs[I_ZH] = 1'b1; ins[I_HI] = 1'b1; tick();
        outs[I_ZL] = 1'b1; ins[I_LO] = 1'b1; tick();
        read_src(I_HI, 32'hFFFF_FFFF, "mul_hi");
        read_src(I_LO, 32'hFFFF_FFFA, "mul_lo");

        alu_check(32'd17, 32'd5, one_op(O_DIV), 32'd2,  32'd3,         "div");
        alu_check(32'd17, 32'd0, one_op(O_DIV), 32'd17, 32'hFFFF_FFFF, "div0");
        alu_check(32'hFFFF_FFF9, 32'd2, one_op(O_DIV), 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_neg");
        alu_check(32'h8000_0001, 32'd1, one_op(O_SHR),  32'd0, 32'h4000_0000, "shr");
        alu_check(32'h8000_0001, 32'd1, one_op(O_SHRA), 32'd0, 32'hC000_0000, "shra");
        alu_check(32'h8000_0001, 32'd1, one_op(O_ROL),  32'd0, 32'h0000_0003, "rol");
        alu_check(32'h8000_0001, 32'd1, one_op(O_ROR),  32'd0, 32'hC000_0000, "ror");
        alu_check(32'h8000_0001, 32'd1, one_op(O_SHL),  32'd0, 32'h0000_0002, "shl");
        alu_check(32'd5, 32'd7, one_op(O_SUB), 32'd0, 32'hFFFF_FFFE, "sub_wrap");
        alu_check(32'd0, 32'd1, one_op(O_NEG), 32'd0, 32'hFFFF_FFFF, "neg");
        alu_check(32'd10, 32'd20, one_op(O_INC) | one_op(O_ADD), 32'd0, 32'd21, "prio_inc_add");
        alu_check(32'd10, 32'd20, 14'd0, 32'd0, 32'd0, "no_op");

        // Randomized control traffic; the per-cycle compare process does the checking.
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < 26; i++) begin
                ins[i]  = ($urandom_range(7) == 0);
                outs[i] = ($urandom_range(5) == 0);
            end
            for (int i = 0; i < 14; i++) op[i] = ($urandom_range(9) == 0);
            Yin       = ($urandom_range(3) == 0);
            MDMuxread = $urandom_range(1) == 1;
            Mdatain   = $urandom;
            clear     = ($urandom_range(63) == 0);
            @(posedge clock);
            #1;
        end
        idle_ctrl();

        // Reset with every register nonzero; the concurrent R1 load must be ignored.
        for (int i = 0; i < 16; i++) load_reg(i, 32'h1111_1111 * (i + 1));
        load_reg(I_HI, 32'hA0A0_0001); load_reg(I_LO, 32'hB0B0_0002);
        load_reg(I_PC, 32'hC0C0_0003); load_reg(I_MAR, 32'hD0D0_0004);
        load_reg(I_IN, 32'hE0E0_0005); load_reg(I_CSE, 32'hF0F0_0006);
        load_reg(I_IR, 32'h0004_1234);
        alu_check(32'd7, 32'd2, one_op(O_DIV), 32'd1, 32'd3, "pre_clear_z");
        load_y(32'h0000_0042);
        load_mdr(32'hA5A5_A5A5);
        clear = 1'b1; ins[1] = 1'b1; outs[I_MDR] = 1'b1;
        tick();
        for (int i = 0; i < 26; i++) read_src(i, 32'd0, $sformatf("clear_src%0d", i));
        outs[0] = 1'b1; op[O_ADD] = 1'b1; ins[I_ZL] = 1'b1;
        tick();
        read_src(I_ZL, 32'd0, "clear_y");

        check_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
